// File: rtl/pipe_cla_pkg.sv
// -----------------------------------------------------------------------------
// pipe_cla_pkg
//   Shared constants for the pipelined carry-lookahead adder/subtractor.
//   - DEF_WIDTH / DEF_BLOCK : default operand width and lookahead slice width
//   - OP_ADD / OP_SUB       : encodings of the 'sub' operation select input
//   No ports (package).
// -----------------------------------------------------------------------------
package pipe_cla_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : pipe_cla_pkg

// File: rtl/cla_slice.sv
// -----------------------------------------------------------------------------
// cla_slice
//   Combinational BLOCK-bit carry-lookahead slice. Every internal carry is
//   formed directly from the generate/propagate terms and c_in (sum of
//   products), not rippled from the previous bit.
//
// Ports
//   a, b    in  [BLOCK-1:0]  slice operands (b already inverted for subtract)
//   c_in    in  1            carry into bit 0 of the slice
//   sum     out [BLOCK-1:0]  slice sum
//   c_out   out 1            carry out of the slice MSB
//   grp_g   out 1            group generate (carry out assuming c_in = 0)
//   grp_p   out 1            group propagate (all bits propagate)
//   c_msb   out 1            carry into the slice MSB (overflow detection)
// -----------------------------------------------------------------------------
module cla_slice #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] sum,
  output logic             c_out,
  output logic             grp_g,
  output logic             grp_p,
  output logic             c_msb
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic             term;
  logic             pp;
  logic             gg_acc;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c_in
  // 'term' accumulates the generate products, 'pp' the running propagate
  // product walking down from bit i.
  always_comb begin
    c      = '0;
    term   = 1'b0;
    pp     = 1'b0;
    gg_acc = 1'b0;
    c[0]   = c_in;
    for (int i = 0; i < BLOCK; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & c_in);
      if (i == BLOCK - 1) begin
        gg_acc = term;
      end
    end
  end

  assign sum   = p ^ c[BLOCK-1:0];
  assign c_out = c[BLOCK];
  assign c_msb = c[BLOCK-1];
  assign grp_g = gg_acc;
  assign grp_p = &p;

endmodule : cla_slice

// File: rtl/pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// pipe_cla_adder
//   Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is split
//   into STAGES = WIDTH/BLOCK slices; stage k resolves bits [k*BLOCK +: BLOCK]
//   and registers its carry for stage k+1. Latency is STAGES cycles and one
//   operation per cycle is sustained while the consumer is ready.
//   WIDTH must be a multiple of BLOCK and WIDTH > BLOCK (at least two stages).
//
// Configuration macro: PIPE_CLA_FLAGS_EN
//   defined   : c_out / overflow are registered in the last stage and zero is
//               decoded from the registered result.
//   undefined : flag logic removed, c_out / overflow / zero tied to 0.
//
// Ports
//   clock          in  1       rising-edge clock
//   reset_n        in  1       asynchronous active-low reset
//   in_valid       in  1       operand beat offered
//   in_ready       out 1       a beat is accepted this cycle if in_valid
//   data_operandA  in  WIDTH   operand A
//   data_operandB  in  WIDTH   operand B
//   sub            in  1       OP_ADD: A+B, OP_SUB: A-B
//   out_valid      out 1       result beat offered
//   out_ready      in  1       consumer accepts the result
//   data_result    out WIDTH   sum or difference (modulo 2^WIDTH)
//   c_out          out 1       carry out of MSB (subtract: 1 = no borrow)
//   overflow       out 1       two's-complement overflow
//   zero           out 1       data_result == 0 (qualify with out_valid)
// -----------------------------------------------------------------------------
module pipe_cla_adder
  import pipe_cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / BLOCK;

  // Handshake: a beat moves into stage k on a rising edge where its upstream
  // holds valid data and ready[k] is high. ready[k] = !valid_q[k] ||
  // ready[k+1], with ready[STAGES] = out_ready, so a full pipeline stalls in
  // the same cycle the consumer deasserts out_ready, and a full pipeline can
  // accept a new beat in the cycle its oldest beat leaves. A stalled stage
  // keeps its contents unchanged.
  logic [STAGES:0]   ready;
  logic [STAGES-1:0] up_valid;

  // Per-stage registers. Operands are stored pre-shifted so the bits the next
  // stage needs are always at [BLOCK-1:0]; consumed bits are shifted out.
  logic              valid_q [STAGES];
  logic [WIDTH-1:0]  res_q   [STAGES];
  logic [WIDTH-1:0]  a_q     [STAGES-1];
  logic [WIDTH-1:0]  b_q     [STAGES-1];
  logic              carry_q [STAGES-1];

  // Upstream view of each stage (stage 0 looks at the input port).
  logic [WIDTH-1:0]  up_a    [STAGES];
  logic [WIDTH-1:0]  up_b    [STAGES];
  logic [WIDTH-1:0]  up_res  [STAGES];
  logic              up_cin  [STAGES];

  // Slice outputs.
  logic [BLOCK-1:0]  sl_sum  [STAGES];
  logic [STAGES-1:0] sl_cout;
  logic [STAGES-1:0] sl_cmsb;
  logic [STAGES-1:0] sl_gg;
  logic [STAGES-1:0] sl_gp;

  logic              is_sub;
  logic [WIDTH-1:0]  b_eff;

  // Subtraction is A + ~B + 1: invert B and feed the 1 as stage-0 carry-in.
  assign is_sub = (sub == OP_SUB);
  assign b_eff  = is_sub ? ~data_operandB : data_operandB;

  assign ready[STAGES] = out_ready;
  assign in_ready      = ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage

    assign ready[k] = !valid_q[k] || ready[k+1];

    if (k == 0) begin : g_first
      assign up_valid[k] = in_valid;
      assign up_a[k]     = data_operandA;
      assign up_b[k]     = b_eff;
      assign up_res[k]   = '0;
      assign up_cin[k]   = is_sub;
    end else begin : g_next
      assign up_valid[k] = valid_q[k-1];
      assign up_a[k]     = a_q[k-1];
      assign up_b[k]     = b_q[k-1];
      assign up_res[k]   = res_q[k-1];
      assign up_cin[k]   = carry_q[k-1];
    end

    cla_slice #(
      .BLOCK (BLOCK)
    ) u_slice (
      .a     (up_a[k][BLOCK-1:0]),
      .b     (up_b[k][BLOCK-1:0]),
      .c_in  (up_cin[k]),
      .sum   (sl_sum[k]),
      .c_out (sl_cout[k]),
      .grp_g (sl_gg[k]),
      .grp_p (sl_gp[k]),
      .c_msb (sl_cmsb[k])
    );

    // Valid bit and accumulated result bits [0 .. (k+1)*BLOCK-1].
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        valid_q[k] <= 1'b0;
        res_q[k]   <= '0;
      end else if (ready[k]) begin
        valid_q[k] <= up_valid[k];
        if (up_valid[k]) begin
          res_q[k] <= up_res[k] | (WIDTH'(sl_sum[k]) << (k * BLOCK));
        end
      end
    end

    // Unconsumed operand bits and the slice carry, needed only by later stages.
    if (k < STAGES - 1) begin : g_carry
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_q[k]     <= '0;
          b_q[k]     <= '0;
          carry_q[k] <= 1'b0;
        end else if (ready[k] && up_valid[k]) begin
          a_q[k]     <= up_a[k] >> BLOCK;
          b_q[k]     <= up_b[k] >> BLOCK;
          carry_q[k] <= sl_cout[k];
        end
      end
    end

  end : g_stage

  assign out_valid   = valid_q[STAGES-1];
  assign data_result = res_q[STAGES-1];

`ifdef PIPE_CLA_FLAGS_EN
  logic cout_q;
  logic ovf_q;

  // Overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (ready[STAGES-1] && up_valid[STAGES-1]) begin
      cout_q <= sl_cout[STAGES-1];
      ovf_q  <= sl_cout[STAGES-1] ^ sl_cmsb[STAGES-1];
    end
  end

  assign c_out    = cout_q;
  assign overflow = ovf_q;
  assign zero     = (data_result == '0);
`else
  assign c_out    = 1'b0;
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  // Group terms, non-final slice flags and the last stage's leftover operand
  // bits have no consumer here; gather them so they are visibly intentional.
  logic unused_slice_bits;
  assign unused_slice_bits = ^{sl_gg, sl_gp, sl_cmsb, sl_cout,
                               up_a[STAGES-1], up_b[STAGES-1]};

endmodule : pipe_cla_adder

// File: tb/tb_pipe_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_cla_adder
//   Self-checking bench for pipe_cla_adder (WIDTH=32, BLOCK=8). The driver
//   pushes the reference result of each accepted beat into exp_q; a monitor on
//   the falling edge pops and compares every delivered result, and also checks
//   the ready chain, output hold under stall and no-stall latency.
// -----------------------------------------------------------------------------
module tb_pipe_cla_adder;
  import pipe_cla_pkg::*;

  localparam int W      = 32;
  localparam int BLK    = 8;
  localparam int STAGES = W / BLK;

`ifdef PIPE_CLA_FLAGS_EN
  localparam logic ZERO_AT_RST = 1'b1;
`else
  localparam logic ZERO_AT_RST = 1'b0;
`endif

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_result;
  logic         c_out;
  logic         overflow;
  logic         zero;

  // Scoreboard: {zero, overflow, c_out, result} per accepted beat.
  logic [W+2:0] exp_q[$];
  int           t_q[$];

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           bp_mode = 0;
  int           in_flight = 0;
  logic         prev_stall = 1'b0;
  logic [W+2:0] prev_out = '0;
  logic [W+2:0] mon_exp;
  int           mon_t;

  pipe_cla_adder #(
    .WIDTH (W),
    .BLOCK (BLK)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .sub           (sub),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_result   (data_result),
    .c_out         (c_out),
    .overflow      (overflow),
    .zero          (zero)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [W+2:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic s);
    longint       ua;
    longint       ub;
    longint       sa;
    longint       sb;
    longint       full;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         z;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r    = a - b;
      co   = (ua >= ub);
      full = sa - sb;
    end else begin
      r    = a + b;
      co   = ((ua + ub) >= 64'h1_0000_0000);
      full = sa + sb;
    end
    ov = (full > 64'sh7FFF_FFFF) || (full < -64'sh8000_0000);
    z  = (r == '0);
`ifndef PIPE_CLA_FLAGS_EN
    co = 1'b0;
    ov = 1'b0;
    z  = 1'b0;
`endif
    return {z, ov, co, r};
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    int  waited;
    bit  done;
    waited        = 0;
    done          = 1'b0;
    in_valid      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    sub           = s;
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 2000) begin
          n_cmp++;
          n_err++;
          $display("FAIL issue_timeout: in_ready stuck at 0 for %0d cycles", waited);
          in_valid = 1'b0;
          return;
        end
      end
    end
    exp_q.push_back(model(a, b, s));
    t_q.push_back(cyc);
    @(posedge clock);
    #1;
    in_valid      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    sub           = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clock);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
    end
    idle(2);
  endtask

  task automatic set_mode(input int m);
    bp_mode = m;
    idle(2);
  endtask

  // Consumer readiness: always ready, or ready about 40% of cycles.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = (bp_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 40);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset_n) begin
      in_flight  = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready_chain", in_ready, !((in_flight == STAGES) && !out_ready));
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", {zero, overflow, c_out, data_result}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got result %h with no beat outstanding",
                   data_result);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_t   = t_q.pop_front();
          check("result", {zero, overflow, c_out, data_result}, mon_exp);
          if (bp_mode == 0) begin
            check("latency", cyc - mon_t, STAGES);
          end
        end
      end
      in_flight  = in_flight + ((in_valid && in_ready) ? 1 : 0)
                             - ((out_valid && out_ready) ? 1 : 0);
      prev_stall = out_valid && !out_ready;
      prev_out   = {zero, overflow, c_out, data_result};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n       = 1'b0;
    in_valid      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    sub           = OP_ADD;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      in_valid      = 1'($urandom_range(0, 1));
      data_operandA = $urandom;
      data_operandB = $urandom;
      sub           = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_data", data_result, '0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_flags", {zero, overflow, c_out}, {ZERO_AT_RST, 2'b00});
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    idle(6);
    @(negedge clock);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);
    idle(1);

    // Directed corners.
    issue(32'h0000_00FF, 32'h0000_0001, OP_ADD);
    idle(5);
    issue(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
    issue(32'h8000_0000, 32'h0000_0001, OP_SUB);
    issue(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
    issue(32'h0000_0000, 32'h0000_0001, OP_SUB);
    issue(32'h1234_5678, 32'h1234_5678, OP_SUB);
    issue(32'h8000_0000, 32'h8000_0000, OP_ADD);
    drain();

    // Random traffic, consumer always ready.
    for (int i = 0; i < 120; i++) begin
      issue(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Random traffic under backpressure.
    set_mode(1);
    for (int i = 0; i < 150; i++) begin
      issue(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    drain();

    // Ten back-to-back beats A = i, B = 3i under backpressure: results 4i.
    for (int i = 0; i < 10; i++) begin
      issue(W'(i), W'(3 * i), OP_ADD);
    end
    drain();
    set_mode(0);

    // Mid-flight reset: three beats in the pipe are discarded.
    issue(32'h0000_0011, 32'h0000_0022, OP_ADD);
    issue(32'h0000_0033, 32'h0000_0044, OP_SUB);
    issue(32'h0000_0055, 32'h0000_0066, OP_ADD);
    reset_n = 1'b0;
    exp_q.delete();
    t_q.delete();
    @(negedge clock);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_data", data_result, '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(6);
    issue(32'd5, 32'd7, OP_ADD);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_cla_adder
